// File: rtl/sseg_bcd.sv
// rtl/sseg_bcd.sv - sequential 27-bit binary to 8-digit packed BCD converter
//
// Purpose:
//   Converts an unsigned 27-bit value to eight packed BCD digits using a
//   shift-and-add-3 (double-dabble) loop, one bit per clock. One conversion
//   takes 28 cycles from the accepting edge to the done pulse. The result
//   feeds the dat input of sseg_drv.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   rst_n  in   1   asynchronous active-low reset
//   start  in   1   conversion request, honoured only while idle
//   bin    in  27   value to convert, captured on the accepting edge
//   busy   out  1   conversion in progress
//   done   out  1   one-cycle pulse, bcd/ovf valid from this cycle
//   bcd    out 32   packed digits, digit 7 in [31:28], digit 0 in [3:0]
//   ovf    out  1   last converted value exceeded 99,999,999
//
// Configuration:
//   SSEG_BCD_SAT_EN  when defined, an overflowing value reads as 32'h99999999;
//                    otherwise bcd holds the low eight decimal digits.

module sseg_bcd (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [26:0] bin,
  output logic        busy,
  output logic        done,
  output logic [31:0] bcd,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [26:0] operand;   // remaining binary bits, consumed MSB first
  logic [35:0] work;      // nine BCD digits; digit 8 only flags overflow
  logic [4:0]  cnt;       // shifts still to perform
  logic [35:0] work_adj;  // work after the add-3 correction
  logic [62:0] shifted;   // {work_adj, operand} moved up by one bit

  // Any digit >= 5 would become >= 10 after doubling, so pre-add 3 to make
  // the doubling carry into the next digit correctly.
  always_comb begin
    work_adj = work;
    for (int d = 0; d < 9; d++) begin
      if (work[4*d +: 4] >= 4'd5) begin
        work_adj[4*d +: 4] = work[4*d +: 4] + 4'd3;
      end
    end
  end

  // The bit shifted out of the top of digit 8 is always zero because the
  // input never exceeds 134,217,727.
  assign shifted = {work_adj, operand} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      bcd     <= 32'h0000_0000;
      cnt     <= 5'd0;
      work    <= 36'd0;
      operand <= 27'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            operand <= bin;
            work    <= 36'd0;
            cnt     <= 5'd27;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          work    <= shifted[62:27];
          operand <= shifted[26:0];
          cnt     <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            state <= DONE;
          end
        end

        DONE: begin
          // Digit 8 is nonzero exactly when the value exceeds 99,999,999.
          ovf <= (work[35:32] != 4'd0);
`ifdef SSEG_BCD_SAT_EN
          bcd <= (work[35:32] != 4'd0) ? 32'h9999_9999 : work[31:0];
`else
          bcd <= work[31:0];
`endif
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sseg_bcd.sv
// tb/tb_sseg_bcd.sv - self-checking bench for sseg_bcd

module tb_sseg_bcd;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [26:0] bin;
  logic        busy;
  logic        done;
  logic [31:0] bcd;
  logic        ovf;

  sseg_bcd dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;
  int n_done  = 0;

  typedef struct {
    logic [31:0] bcd;
    logic        ovf;
    int          at;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [26:0] bin;
    logic [31:0] bcd;
    logic        ovf;
  } vec_t;

`ifdef SSEG_BCD_SAT_EN
  localparam logic [31:0] OVF_100M = 32'h9999_9999;
  localparam logic [31:0] OVF_MAX  = 32'h9999_9999;
`else
  localparam logic [31:0] OVF_100M = 32'h0000_0000;
  localparam logic [31:0] OVF_MAX  = 32'h3421_7727;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] model_bcd(input logic [26:0] v);
    logic [31:0] r;
    int unsigned x;
    x = v;
    r = '0;
`ifdef SSEG_BCD_SAT_EN
    if (x > 99999999) return 32'h9999_9999;
`endif
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Result monitor: pops the scoreboard on every done pulse.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (prev_done) check("done_pulse_width", done, 0);
      if (done) begin
        n_done++;
        check("busy_at_done", busy, 0);
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("bcd", bcd, e.bcd);
          check("ovf", ovf, e.ovf);
          check("done_cycle", cyc, e.at);
        end
      end
    end
    prev_done = rst_n ? done : 1'b0;
  end

  task automatic wait_drain(input int max_cyc);
    int i;
    i = 0;
    while (sb.size() != 0 && i < max_cyc) begin
      @(negedge clk); #1;
      i++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Called in the low clock phase; the next rising edge accepts the start.
  task automatic do_conv(input logic [26:0] v, input logic [31:0] eb, input logic eo);
    int n;
    logic ok;
    start = 1'b1;
    bin   = v;
    @(posedge clk); #1;
    start = 1'b0;
    n = cyc;
    sb.push_back('{bcd: eb, ovf: eo, at: n + 28});
    bin = 27'($urandom);
    ok = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk); #1;
      if (!busy || done) ok = 1'b0;
    end
    check("busy_window", ok, 1);
    wait_drain(5);
  endtask

  vec_t vecs[13];

  initial begin
    int n;
    int d0;
    logic [26:0] v;

    vecs[0]  = '{bin: 27'd0,         bcd: 32'h0000_0000, ovf: 1'b0};
    vecs[1]  = '{bin: 27'd12345678,  bcd: 32'h1234_5678, ovf: 1'b0};
    vecs[2]  = '{bin: 27'd99999999,  bcd: 32'h9999_9999, ovf: 1'b0};
    vecs[3]  = '{bin: 27'd100000000, bcd: OVF_100M,      ovf: 1'b1};
    vecs[4]  = '{bin: 27'd134217727, bcd: OVF_MAX,       ovf: 1'b1};
    vecs[5]  = '{bin: 27'd1,         bcd: 32'h0000_0001, ovf: 1'b0};
    vecs[6]  = '{bin: 27'd9,         bcd: 32'h0000_0009, ovf: 1'b0};
    vecs[7]  = '{bin: 27'd10,        bcd: 32'h0000_0010, ovf: 1'b0};
    vecs[8]  = '{bin: 27'd99,        bcd: 32'h0000_0099, ovf: 1'b0};
    vecs[9]  = '{bin: 27'd100,       bcd: 32'h0000_0100, ovf: 1'b0};
    vecs[10] = '{bin: 27'd5,         bcd: 32'h0000_0005, ovf: 1'b0};
    vecs[11] = '{bin: 27'd10000000,  bcd: 32'h1000_0000, ovf: 1'b0};
    vecs[12] = '{bin: 27'd98765432,  bcd: 32'h9876_5432, ovf: 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bcd",  bcd,  0);
    check("rst_ovf",  ovf,  0);
    rst_n = 1'b1;

    // Table vectors.
    for (int i = 0; i < 13; i++) do_conv(vecs[i].bin, vecs[i].bcd, vecs[i].ovf);

    // Random vectors against the decimal model.
    for (int r = 0; r < 6; r++) begin
      v = 27'($urandom);
      do_conv(v, model_bcd(v), v > 27'd99999999);
    end

    // Start while busy is ignored; bin changes in flight have no effect.
    d0 = n_done;
    start = 1'b1;
    bin   = 27'd12345678;
    @(posedge clk); #1;
    start = 1'b0;
    n = cyc;
    sb.push_back('{bcd: 32'h1234_5678, ovf: 1'b0, at: n + 28});
    bin = 27'd3;
    while (cyc < n + 4) begin @(negedge clk); #1; end
    start = 1'b1;
    bin   = 27'd42;
    @(posedge clk); #1;
    start = 1'b0;
    bin   = 27'd77777777;
    check("busy_after_restart_try", busy, 1);
    wait_drain(40);
    repeat (5) begin @(negedge clk); #1; end
    check("single_done", n_done - d0, 1);

    // Reset in flight: outputs clear immediately, no done from the aborted run.
    do_conv(27'd134217727, OVF_MAX, 1'b1);
    start = 1'b1;
    bin   = 27'd12345678;
    @(posedge clk); #1;
    start = 1'b0;
    n = cyc;
    while (cyc < n + 10) begin @(negedge clk); #1; end
    d0 = n_done;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_bcd",  bcd,  0);
    check("midrst_ovf",  ovf,  0);
    check("midrst_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_conv(27'd7, 32'h0000_0007, 1'b0);
    repeat (20) begin @(negedge clk); #1; end
    check("midrst_done_count", n_done - d0, 1);

    // Start held high: back-to-back conversions every 29 cycles.
    start = 1'b1;
    bin   = 27'd5;
    @(posedge clk); #1;
    n = cyc;
    sb.push_back('{bcd: 32'h0000_0005, ovf: 1'b0, at: n + 28});
    sb.push_back('{bcd: 32'h0000_0005, ovf: 1'b0, at: n + 57});
    sb.push_back('{bcd: 32'h0000_0005, ovf: 1'b0, at: n + 86});
    while (cyc < n + 28) begin @(negedge clk); #1; end
    check("cont_busy_gap", busy, 0);
    @(negedge clk); #1;
    check("cont_busy_resume", busy, 1);
    while (cyc < n + 60) begin @(negedge clk); #1; end
    start = 1'b0;
    wait_drain(40);
    check("cont_all_done", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
